// File: rtl/frogger_pkg.sv
// Shared types and default grid constants for the Frogger core.
package frogger_pkg;

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    HIT  = 2'd1,
    OVER = 2'd2
  } game_state_t;

  localparam int unsigned DEF_ROWS = 16;
  localparam int unsigned DEF_COLS = 16;

endpackage

// File: rtl/frogger_hit_timer.sv
// Post-collision freeze timer: loads HIT_CYCLES-1 and counts down to zero.
module frogger_hit_timer #(
  parameter  int unsigned HIT_CYCLES = 8,
  localparam int unsigned TW         = (HIT_CYCLES > 1) ? $clog2(HIT_CYCLES) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic done,
  output logic odd_c
);

  logic [TW-1:0] count;

  // Down-counter; holds at zero once expired.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= TW'(HIT_CYCLES - 1);
    end else if (count != '0) begin
      count <= count - TW'(1);
    end
  end

  assign done  = (count == '0);
  assign odd_c = count[0];

endmodule

// File: rtl/frogger_core.sv
// Frog control, collision/lives/score rules and pixel-plane composition.
module frogger_core
  import frogger_pkg::*;
#(
  parameter  int unsigned ROWS       = DEF_ROWS,
  parameter  int unsigned COLS       = DEF_COLS,
  parameter  int unsigned START_COL  = 7,
  parameter  int unsigned LIVES      = 3,
  parameter  int unsigned HIT_CYCLES = 8,
  parameter  int unsigned SCORE_W    = 4,
  localparam int unsigned RW         = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned CW         = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int unsigned LW         = $clog2(LIVES + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       move_up,
  input  logic                       move_down,
  input  logic                       move_left,
  input  logic                       move_right,
  input  logic [ROWS-1:0][COLS-1:0]  hazard,
  output logic [RW-1:0]              frog_row,
  output logic [CW-1:0]              frog_col,
  output logic [LW-1:0]              lives,
  output logic [SCORE_W-1:0]         score,
  output game_state_t                state,
  output logic                       game_over,
  output logic [ROWS-1:0][COLS-1:0]  red_pixels,
  output logic [ROWS-1:0][COLS-1:0]  grn_pixels
);

  localparam logic [RW-1:0]      ROW_MAX   = RW'(ROWS - 1);
  localparam logic [CW-1:0]      COL_MAX   = CW'(COLS - 1);
  localparam logic [CW-1:0]      COL_START = CW'(START_COL);
  localparam logic [LW-1:0]      LIVES_INI = LW'(LIVES);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  logic frog_hit_c;
  logic hit_done;
  logic hit_odd;

  // Collision is judged on the registered frog position.
  assign frog_hit_c = (state == PLAY) && hazard[frog_row][frog_col];

  frogger_hit_timer #(
    .HIT_CYCLES(HIT_CYCLES)
  ) u_hit_timer (
    .clk  (clk),
    .reset(reset),
    .load (frog_hit_c),
    .done (hit_done),
    .odd_c(hit_odd)
  );

  // Game FSM: hit > win > move priority in PLAY, freeze in HIT, wait for start in OVER.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= PLAY;
      frog_row  <= '0;
      frog_col  <= COL_START;
      lives     <= LIVES_INI;
      score     <= '0;
      game_over <= 1'b0;
    end else begin
      case (state)
        PLAY: begin
          if (frog_hit_c) begin
            lives <= lives - LW'(1);
            if (lives == LW'(1)) begin
              state     <= OVER;
              game_over <= 1'b1;
            end else begin
              state <= HIT;
            end
          end else if (frog_row == ROW_MAX) begin
            if (score != SCORE_MAX) score <= score + SCORE_W'(1);
            frog_row <= '0;
            frog_col <= COL_START;
          end else begin
            if (move_up && !move_down && frog_row != '0)
              frog_row <= frog_row - RW'(1);
            else if (move_down && !move_up && frog_row != ROW_MAX)
              frog_row <= frog_row + RW'(1);
            if (move_left && !move_right && frog_col != '0)
              frog_col <= frog_col - CW'(1);
            else if (move_right && !move_left && frog_col != COL_MAX)
              frog_col <= frog_col + CW'(1);
          end
        end
        HIT: begin
          if (hit_done) begin
            state    <= PLAY;
            frog_row <= '0;
            frog_col <= COL_START;
          end
        end
        OVER: begin
          if (start) begin
            state     <= PLAY;
            game_over <= 1'b0;
            lives     <= LIVES_INI;
            score     <= '0;
            frog_row  <= '0;
            frog_col  <= COL_START;
          end
        end
        default: state <= PLAY;
      endcase
    end
  end

  // Pixel planes: hazards in red, frog in green (blinking while frozen, hidden when over).
  always_comb begin
    red_pixels = hazard;
    grn_pixels = '0;
    if (state == PLAY || (state == HIT && !hit_odd))
      grn_pixels[frog_row][frog_col] = 1'b1;
  end

endmodule

// File: tb/tb_frogger_core.sv
// Self-checking bench for frogger_core against a behavioural game model.
module tb_frogger_core;
  import frogger_pkg::*;

  localparam int R  = 16;
  localparam int C  = 16;
  localparam int SC = 7;
  localparam int LV = 3;
  localparam int HC = 8;
  localparam int SW = 2;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                start = 1'b0;
  logic                move_up = 1'b0, move_down = 1'b0, move_left = 1'b0, move_right = 1'b0;
  logic [R-1:0][C-1:0] hazard = '0;
  logic [3:0]          frog_row;
  logic [3:0]          frog_col;
  logic [1:0]          lives;
  logic [SW-1:0]       score;
  game_state_t         state;
  logic                game_over;
  logic [R-1:0][C-1:0] red_pixels;
  logic [R-1:0][C-1:0] grn_pixels;

  frogger_core #(
    .ROWS(R), .COLS(C), .START_COL(SC), .LIVES(LV), .HIT_CYCLES(HC), .SCORE_W(SW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .move_up(move_up), .move_down(move_down), .move_left(move_left), .move_right(move_right),
    .hazard(hazard),
    .frog_row(frog_row), .frog_col(frog_col), .lives(lives), .score(score),
    .state(state), .game_over(game_over),
    .red_pixels(red_pixels), .grn_pixels(grn_pixels)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Behavioural model: position, lives, score, state, cycles spent in HIT.
  int          m_row, m_col, m_lives, m_score, m_hitk;
  game_state_t m_state;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_plane(input string name, input logic [R-1:0][C-1:0] act,
                           input logic [R-1:0][C-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_row = 0; m_col = SC; m_lives = LV; m_score = 0; m_state = PLAY; m_hitk = 0;
  endtask

  // Frog is visible in PLAY; in HIT only while the remaining-cycle count is even.
  function automatic logic [R-1:0][C-1:0] exp_grn();
    logic [R-1:0][C-1:0] g;
    g = '0;
    if (m_state == PLAY || (m_state == HIT && ((HC - 1 - m_hitk) % 2 == 0)))
      g[m_row][m_col] = 1'b1;
    return g;
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("frog_row", 64'(frog_row), 64'(m_row));
      chk("frog_col", 64'(frog_col), 64'(m_col));
      chk("lives", 64'(lives), 64'(m_lives));
      chk("score", 64'(score), 64'(m_score));
      chk("state", 64'(state), 64'(m_state));
      chk("game_over", 64'(game_over), 64'(m_state == OVER));
      chk_plane("red_pixels", red_pixels, hazard);
      chk_plane("grn_pixels", grn_pixels, exp_grn());
    end
  end

  // Advance one clock: evaluate game rules on current inputs, then commit after the edge.
  task automatic tick();
    int nr, nc, nl, ns_score, nk, v, h;
    game_state_t ns;
    nr = m_row; nc = m_col; nl = m_lives; ns_score = m_score; nk = m_hitk; ns = m_state;
    case (m_state)
      PLAY: begin
        if (hazard[m_row][m_col]) begin
          nl = m_lives - 1;
          if (nl == 0) ns = OVER;
          else begin ns = HIT; nk = 0; end
        end else if (m_row == R - 1) begin
          ns_score = (m_score == (1 << SW) - 1) ? m_score : m_score + 1;
          nr = 0; nc = SC;
        end else begin
          v = int'(move_down) - int'(move_up);
          h = int'(move_right) - int'(move_left);
          nr = m_row + v;
          nc = m_col + h;
          if (nr < 0 || nr > R - 1) nr = m_row;
          if (nc < 0 || nc > C - 1) nc = m_col;
        end
      end
      HIT: begin
        if (m_hitk == HC - 1) begin ns = PLAY; nr = 0; nc = SC; end
        else nk = m_hitk + 1;
      end
      default: begin
        if (start) begin
          ns = PLAY; nl = LV; ns_score = 0; nr = 0; nc = SC;
        end
      end
    endcase
    @(posedge clk);
    #1;
    m_row = nr; m_col = nc; m_lives = nl; m_score = ns_score; m_hitk = nk; m_state = ns;
    move_up = 1'b0; move_down = 1'b0; move_left = 1'b0; move_right = 1'b0; start = 1'b0;
  endtask

  task automatic pulse(input bit u, input bit d, input bit l, input bit r);
    move_up = u; move_down = d; move_left = l; move_right = r;
    tick();
  endtask

  int win_exp[5] = '{1, 2, 3, 3, 3};

  initial begin
    model_reset();
    #1 reset = 1'b0;
    #1 check_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Reset values and edge clamping.
    chk("rst_row", 64'(frog_row), 64'd0);
    chk("rst_col", 64'(frog_col), 64'd7);
    chk("rst_lives", 64'(lives), 64'd3);
    chk("rst_state", 64'(state), 64'(PLAY));
    repeat (8) pulse(0, 0, 1, 0);
    chk("left_edge_col", 64'(frog_col), 64'd0);
    pulse(1, 0, 0, 0);
    chk("top_edge_row", 64'(frog_row), 64'd0);

    // Walk to (3,7), then opposing vertical pulses cancel while right applies.
    repeat (3) pulse(0, 1, 0, 1);
    repeat (4) pulse(0, 0, 0, 1);
    chk("pos3_7_row", 64'(frog_row), 64'd3);
    chk("pos3_7_col", 64'(frog_col), 64'd7);
    pulse(1, 1, 0, 1);
    chk("cancel_row", 64'(frog_row), 64'd3);
    chk("cancel_col", 64'(frog_col), 64'd8);

    // Hit and freeze.
    hazard[2][7] = 1'b1;
    pulse(0, 0, 1, 0);
    pulse(1, 0, 0, 0);
    chk("on_hazard_row", 64'(frog_row), 64'd2);
    pulse(0, 0, 0, 1);
    chk("hit_state", 64'(state), 64'(HIT));
    chk("hit_lives", 64'(lives), 64'd2);
    for (int i = 0; i < HC; i++) begin
      chk("freeze_state", 64'(state), 64'(HIT));
      chk("freeze_col", 64'(frog_col), 64'd7);
      chk("blink", 64'(grn_pixels[2][7]), 64'(i % 2));
      pulse(0, 1, 1, 0);
    end
    chk("respawn_state", 64'(state), 64'(PLAY));
    chk("respawn_row", 64'(frog_row), 64'd0);
    chk("respawn_col", 64'(frog_col), 64'd7);

    // Two more hits end the game.
    repeat (2) pulse(0, 1, 0, 0);
    tick();
    chk("hit2_lives", 64'(lives), 64'd1);
    repeat (HC) tick();
    repeat (2) pulse(0, 1, 0, 0);
    tick();
    chk("over_state", 64'(state), 64'(OVER));
    chk("over_flag", 64'(game_over), 64'd1);
    chk_plane("over_grn", grn_pixels, '0);
    pulse(1, 0, 1, 0);
    chk("over_frozen_row", 64'(frog_row), 64'd2);
    start = 1'b1;
    tick();
    chk("start_lives", 64'(lives), 64'd3);
    chk("start_score", 64'(score), 64'd0);
    chk("start_state", 64'(state), 64'(PLAY));

    // Crossings with score saturation at 3.
    hazard = '0;
    for (int k = 0; k < 5; k++) begin
      repeat (R - 1) pulse(0, 1, 0, 0);
      chk("goal_row", 64'(frog_row), 64'(R - 1));
      tick();
      chk("win_score", 64'(score), 64'(win_exp[k]));
      chk("win_row", 64'(frog_row), 64'd0);
      chk("win_col", 64'(frog_col), 64'd7);
    end

    // Asynchronous reset in the middle of HIT.
    hazard[0][7] = 1'b1;
    tick();
    chk("hit3_state", 64'(state), 64'(HIT));
    repeat (3) tick();
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("arst_state", 64'(state), 64'(PLAY));
    chk("arst_lives", 64'(lives), 64'd3);
    chk("arst_score", 64'(score), 64'd0);
    chk("arst_col", 64'(frog_col), 64'd7);
    hazard = '0;
    @(posedge clk);
    #1 reset = 1'b1;

    // Randomised play against the model.
    repeat (3000) begin
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 2) == 0) hazard = '0;
        else
          for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
              hazard[r][c] = ($urandom_range(0, 15) == 0);
      end
      move_up    = ($urandom_range(0, 5) == 0);
      move_down  = ($urandom_range(0, 1) == 0);
      move_left  = ($urandom_range(0, 3) == 0);
      move_right = ($urandom_range(0, 3) == 0);
      start      = ($urandom_range(0, 7) == 0);
      tick();
    end

    @(negedge clk);
    #1 check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frogger_core.md
# frogger_core

Parametrised frog-control and game-rules engine for the LED-matrix Frogger design. It sits between the edge-detected button inputs, the obstacle-lane generator and the matrix driver. It tracks frog position, resolves collisions against an arbitrary hazard map, manages lives, score and a game-over state, and composes the red/green pixel planes. Grid size, lives, hit-freeze time and score width are generics, replacing the fixed 16×16 single-life core.

## Interface
- `ROWS`, default 16: grid rows; row 0 is the start row and row `ROWS-1` is the goal row.
- `COLS`, default 16: grid columns.
- `START_COL`, default 7: respawn column; must be less than `COLS`.
- `LIVES`, default 3: lives per game; minimum 1.
- `HIT_CYCLES`, default 8: freeze length after a collision; minimum 1.
- `SCORE_W`, default 4: score width; the score saturates at 2^SCORE_W−1.
- `clk  in  1`: single clock for the whole block.
- `reset  in  1`: asynchronous, active-low reset.
- `start  in  1`: one-cycle pulse; leaves `OVER` and begins a new game.
- `move_up`, `move_down`, `move_left`, `move_right  in  1 each`: one-cycle pulses, already edge-detected upstream.
- `hazard  in  [ROWS-1:0][COLS-1:0]`: a 1 marks an occupied cell. Must be stable relative to `clk`.
- `frog_row  out  $clog2(ROWS)`: registered frog row.
- `frog_col  out  $clog2(COLS)`: registered frog column.
- `lives  out  $clog2(LIVES+1)`: remaining lives.
- `score  out  SCORE_W`: number of crossings completed.
- `state  out  2`: current FSM state, type `game_state_t`.
- `game_over  out  1`: high exactly while in `OVER`.
- `red_pixels`, `grn_pixels  out  [ROWS-1:0][COLS-1:0]`: pixel planes for the matrix driver.

## Operation
- FSM states: `PLAY`, `HIT`, `OVER`.
- **PLAY**, evaluated in this priority order each cycle:
  1. **Hit:** if `hazard[frog_row][frog_col]` is 1, decrement lives. Go to `OVER` if lives was 1, otherwise to `HIT`. All moves that cycle are ignored.
  2. **Win:** else, if `frog_row == ROWS-1`, increment score (saturating), respawn the frog at (0, `START_COL`) and stay in `PLAY`.
  3. **Move:** otherwise apply moves.
     - Up decrements the row; down increments it; left decrements the column; right increments it.
     - Opposing pulses in the same cycle cancel.
     - One vertical and one horizontal move may apply in the same cycle.
     - A move past a grid edge is dropped; there is no wrap.
- **HIT**
  - Frog is frozen at the collision cell; moves and hazards are ignored.
  - A down-counter loads `HIT_CYCLES-1` on entry.
  - When the counter reaches 0: respawn the frog at (0, `START_COL`) and go to `PLAY`.
- **OVER**
  - Frog is frozen and all moves are ignored.
  - `start` loads lives = `LIVES`, score = 0, respawns the frog and goes to `PLAY`.
  - `start` is ignored in `PLAY` and `HIT`.
- **Pixels** (combinational from registers and `hazard`):
  - `red_pixels` = `hazard`.
  - `grn_pixels` has a single 1 at the frog cell, except:
    - in `HIT`, that 1 is shown only when the counter's bit 0 is 0 (blink);
    - in `OVER`, `grn_pixels` is all 0.

## Timing
- Reset (asynchronous assert) sets: state `PLAY`, frog at (0, `START_COL`), lives = `LIVES`, score = 0, hit counter = 0, `game_over` = 0.
- A move pulse in cycle N is visible on `frog_row`/`frog_col` at N+1.
- Hazard sampling uses the registered position, so a collision caused by a move is detected one cycle after the move lands. A hazard under the frog at N gives state `HIT` and decremented `lives` at N+1.
- `HIT` lasts exactly `HIT_CYCLES` cycles. `PLAY` resumes with the frog at the start cell.
- A win is detected the cycle after the frog lands on `ROWS-1`. Score updates and the respawn happens at the following edge.
- Reset asserted mid-`HIT` or mid-`OVER` returns immediately to the reset values.

## Structure
- Package `frogger_pkg` holds:
  - `typedef enum logic [1:0] {PLAY, HIT, OVER} game_state_t`;
  - the shared default constants for `ROWS` and `COLS`.
- Sub-module `frogger_hit_timer` provides the parametrised `HIT_CYCLES` down-counter with `load` and `done` signals.
- Everything else lives in one `always_ff` block plus one `always_comb` pixel block.

## Test plan
- **Reset and edges:** release reset, pulse `move_left` 8 times → `frog_col` is 0 (the 8th pulse is dropped). Then pulse `move_up` → `frog_row` stays 0.
- **Cancel:** pulse `move_up`, `move_down` and `move_right` together from (3, 7) → frog at (3, 8).
- **Hit and freeze:** place a hazard at (2, 7) and walk the frog onto it → next cycle state is `HIT` and lives is 2. For 8 cycles moves are ignored and the green pixel blinks. Then the frog is at (0, 7) in `PLAY`.
- **Game over:** take 3 hits → state `OVER`, `game_over` = 1, `grn_pixels` = 0. Pulse `start` → lives 3, score 0, state `PLAY`.
- **Win and saturate:** with `SCORE_W` = 2 and no hazards, complete 5 crossings → score reads 1, 2, 3, 3, 3, with a respawn at (0, 7) after each crossing.
- **Async reset mid-HIT:** assert `reset` low between clock edges while in `HIT` → outputs reach their reset values immediately.
